// File: rtl/uart_dbg_pkg.sv
// Shared constants and state types for the UART debug bridge.
package uart_dbg_pkg;

  // Command opcodes received from the host
  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_READ     = 8'h52;

  // Single-byte replies sent back to the host
  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_BADOP   = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h45;

  // Index of the stop bit within a 10-bit serial frame (0 = start bit)
  localparam logic [3:0] TX_STOP_BIT = 4'd9;

  // Command parser states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_REPLY
  } state_e;

  // Receiver states
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Little-endian accumulation: each new byte enters at the top, so after
  // four bytes the first one received sits in bits [7:0].
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  b);
    return {b, word[31:8]};
  endfunction

endpackage

// File: rtl/uart_dbg_bridge_if.sv
// Request/response bus between the debug bridge (master) and the SoC arbiter.
interface uart_dbg_bridge_if;
  logic [31:0] req_addr_o;
  logic [31:0] req_value_o;
  logic [3:0]  req_wstrb_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] resp_value_i;
  logic        resp_valid_i;

  modport master (
    output req_addr_o, req_value_o, req_wstrb_o, req_valid_o,
    input  req_ready_i, resp_value_i, resp_valid_i
  );

  modport slave (
    input  req_addr_o, req_value_o, req_wstrb_o, req_valid_o,
    output req_ready_i, resp_value_i, resp_valid_i
  );
endinterface

// File: rtl/uart_dbg_rx.sv
// 8N1 UART receiver: synchronizer, start-bit validation, mid-bit sampling and
// framing check. Emits one-cycle byte and framing-error strobes.
module uart_dbg_rx
  import uart_dbg_pkg::*;
#(
  parameter int DIV = 650
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int                 CNT_W  = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0]   DIV_C  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]   HALF_C = CNT_W'(DIV >> 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Next-state logic: count bit periods and sample at mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is gone by mid-bit was a glitch
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_C) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == DIV_C) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // Wait for the line to return high so a low stop bit is not
        // mistaken for the next start bit
        cnt_d = '0;
        if (rx_sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Control registers and the two-flop synchronizer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Data shift register needs no reset; it is only read with valid_q
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: parses W/R command frames, issues a single bus
// transaction and serialises the reply back over tx_o.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int DIV     = 650,
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o,
  output logic busy_o,
  uart_dbg_bridge_if.master bus
);

  localparam int               CNT_W  = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
  localparam int               TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;

  state_e           state_q;
  logic             is_wr_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [31:0]      req_addr_q;
  logic [31:0]      req_value_q;
  logic [3:0]       req_wstrb_q;
  logic             req_valid_q;
  logic [TMO_W-1:0] tmo_q;
  logic [31:0]      reply_q;
  logic [2:0]       reply_left_q;
  logic             tx_q;
  logic             tx_active_q;
  logic [3:0]       tx_bit_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [7:0]       tx_byte_q;
  logic             busy_q;
  logic             tx_load;

  uart_dbg_rx #(.DIV(DIV)) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .valid_o     (rx_valid),
    .frame_err_o (rx_err)
  );

  // Start a new TX byte on entry to REPLY or straight after a stop bit
  always_comb begin
    tx_load = 1'b0;
    if (state_q == ST_REPLY) begin
      if (!tx_active_q)
        tx_load = 1'b1;
      else if (tx_cnt_q == DIV_C && tx_bit_q == TX_STOP_BIT && reply_left_q != 3'd0)
        tx_load = 1'b1;
    end
  end

  // Command parser, bus handshake, timeout and TX serialiser
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      req_addr_q   <= '0;
      req_value_q  <= '0;
      req_wstrb_q  <= '0;
      req_valid_q  <= 1'b0;
      tmo_q        <= '0;
      reply_q      <= '0;
      reply_left_q <= '0;
      tx_q         <= 1'b1;
      tx_active_q  <= 1'b0;
      tx_bit_q     <= '0;
      tx_cnt_q     <= '0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
              is_wr_q <= (rx_byte == OP_WRITE);
              state_q <= ST_ADDR;
            end else begin
              reply_q      <= {24'h0, RSP_BADOP};
              reply_left_q <= 3'd1;
              state_q      <= ST_REPLY;
            end
          end
        end

        ST_ADDR: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rx_valid) begin
            addr_q     <= shift_in_byte(addr_q, rx_byte);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= ST_DATA;
              end else begin
                req_addr_q  <= shift_in_byte(addr_q, rx_byte);
                req_wstrb_q <= 4'b0000;
                req_valid_q <= 1'b1;
                tmo_q       <= '0;
                state_q     <= ST_BUS_REQ;
              end
            end
          end
        end

        ST_DATA: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rx_valid) begin
            data_q     <= shift_in_byte(data_q, rx_byte);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              req_addr_q  <= addr_q;
              req_value_q <= shift_in_byte(data_q, rx_byte);
              req_wstrb_q <= 4'b1111;
              req_valid_q <= 1'b1;
              tmo_q       <= '0;
              state_q     <= ST_BUS_REQ;
            end
          end
        end

        ST_BUS_REQ: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (bus.req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_BUS_WAIT;
          end else if (tmo_q == TMO_LAST) begin
            req_valid_q  <= 1'b0;
            reply_q      <= {24'h0, RSP_TIMEOUT};
            reply_left_q <= 3'd1;
            state_q      <= ST_REPLY;
          end
        end

        ST_BUS_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (bus.resp_valid_i) begin
            reply_q      <= is_wr_q ? {24'h0, RSP_OK} : bus.resp_value_i;
            reply_left_q <= is_wr_q ? 3'd1 : 3'd4;
            state_q      <= ST_REPLY;
          end else if (tmo_q >= TMO_LAST) begin
            // Acceptance may coincide with the last BUS_REQ cycle, so the
            // count can already be past the limit here
            reply_q      <= {24'h0, RSP_TIMEOUT};
            reply_left_q <= 3'd1;
            state_q      <= ST_REPLY;
          end
        end

        ST_REPLY: begin
          if (tx_load) begin
            tx_active_q  <= 1'b1;
            tx_q         <= 1'b0;
            tx_byte_q    <= reply_q[7:0];
            reply_q      <= reply_q >> 8;
            reply_left_q <= reply_left_q - 3'd1;
            tx_bit_q     <= '0;
            tx_cnt_q     <= '0;
          end else if (tx_cnt_q == DIV_C) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == TX_STOP_BIT) begin
              tx_active_q <= 1'b0;
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              tx_q     <= (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_q[tx_bit_q[2:0]];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o            = tx_q;
  assign busy_o          = busy_q;
  assign bus.req_addr_o  = req_addr_q;
  assign bus.req_value_o = req_value_q;
  assign bus.req_wstrb_o = req_wstrb_q;
  assign bus.req_valid_o = req_valid_q;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge at DIV=15 (16 clocks per bit).
module tb_uart_dbg_bridge;

  localparam int DIV     = 15;
  localparam int TIMEOUT = 1024;
  localparam int BITC    = DIV + 1;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  logic rx_i  = 1'b1;
  logic tx_o;
  logic busy_o;

  uart_dbg_bridge_if bus();

  uart_dbg_bridge #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .rx_i   (rx_i),
    .tx_o   (tx_o),
    .busy_o (busy_o),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Responder configuration and observations
  int          cfg_stall  = 0;
  int          cfg_lat    = 1;
  logic [31:0] cfg_rdata  = 32'h0;
  int          req_count  = 0;
  int          req_cyc    = 0;
  int          stable_err = 0;
  logic [31:0] seen_addr  = 32'h0;
  logic [31:0] seen_value = 32'h0;
  logic [3:0]  seen_wstrb = 4'h0;
  int          tx_low_cyc = 0;

  logic [7:0]  frm [9];

  initial begin : responder
    bus.req_ready_i  = 1'b0;
    bus.resp_valid_i = 1'b0;
    bus.resp_value_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_i && bus.req_valid_o === 1'b1) begin
        req_count++;
        req_cyc    = cyc;
        seen_addr  = bus.req_addr_o;
        seen_value = bus.req_value_o;
        seen_wstrb = bus.req_wstrb_o;
        for (int i = 0; i < cfg_stall; i++) begin
          @(negedge clk);
          if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== seen_addr ||
              bus.req_value_o !== seen_value || bus.req_wstrb_o !== seen_wstrb)
            stable_err++;
        end
        bus.req_ready_i = 1'b1;
        @(negedge clk);
        bus.req_ready_i = 1'b0;
        if (cfg_lat > 0) begin
          repeat (cfg_lat - 1) @(negedge clk);
          bus.resp_value_i = cfg_rdata;
          bus.resp_valid_i = 1'b1;
          @(negedge clk);
          bus.resp_valid_i = 1'b0;
          bus.resp_value_i = 32'h0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx_i = stop;
    repeat (BITC) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_byte(frm[i], 1'b1);
  endtask

  task automatic load_w(input logic [31:0] a, input logic [31:0] d);
    frm[0] = 8'h57;
    for (int i = 0; i < 4; i++) begin
      frm[1 + i] = a[8*i +: 8];
      frm[5 + i] = d[8*i +: 8];
    end
  endtask

  task automatic load_r(input logic [31:0] a);
    frm[0] = 8'h52;
    for (int i = 0; i < 4; i++) frm[1 + i] = a[8*i +: 8];
    for (int i = 5; i < 9; i++) frm[i] = 8'h00;
  endtask

  // Receive one byte from tx_o; returns X on timeout or bad framing
  task automatic get_tx_byte(output logic [7:0] b, input int bound);
    logic [7:0] d;
    logic       st;
    int         n;
    n = 0;
    d = 8'h00;
    while (tx_o !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (tx_o !== 1'b0) begin
      b = 8'hxx;
      return;
    end
    tx_low_cyc = cyc;
    repeat (BITC / 2) @(negedge clk);
    st = tx_o;
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(negedge clk);
      d[i] = tx_o;
    end
    repeat (BITC) @(negedge clk);
    if (st !== 1'b0 || tx_o !== 1'b1) b = 8'hxx;
    else                              b = d;
  endtask

  task automatic wait_busy_low(output logic seen_low);
    seen_low = 1'b0;
    for (int i = 0; i < 2 * BITC && !seen_low; i++) begin
      @(negedge clk);
      if (busy_o === 1'b0) seen_low = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
    checks++; if (bus.req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.req_valid_o); end
    checks++; if (bus.req_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.req_addr_o); end
    checks++; if (bus.req_value_o !== 32'h0) begin errors++; $display("FAIL reset_value got=%h exp=0", bus.req_value_o); end
    checks++; if (bus.req_wstrb_o !== 4'h0) begin errors++; $display("FAIL reset_wstrb got=%h exp=0", bus.req_wstrb_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] r;
    logic       low;
    int         base;
    base = req_count;
    cfg_stall = 0; cfg_lat = 2; cfg_rdata = 32'h0;
    load_w(32'h0000_0010, 32'hDEAD_BEEF);
    fork
      send_frame(9);
      get_tx_byte(r, 9 * 10 * BITC + 200);
    join
    checks++; if (req_count - base != 1) begin errors++; $display("FAIL write_reqcnt got=%0d exp=1", req_count - base); end
    checks++; if (seen_addr !== 32'h10) begin errors++; $display("FAIL write_addr got=%h exp=00000010", seen_addr); end
    checks++; if (seen_value !== 32'hDEADBEEF) begin errors++; $display("FAIL write_value got=%h exp=deadbeef", seen_value); end
    checks++; if (seen_wstrb !== 4'hF) begin errors++; $display("FAIL write_wstrb got=%h exp=f", seen_wstrb); end
    checks++; if (r !== 8'h4B) begin errors++; $display("FAIL write_reply got=%h exp=4b", r); end
    wait_busy_low(low);
    checks++; if (low !== 1'b1) begin errors++; $display("FAIL write_busy_end got=%b exp=1", low); end
    checks++; if (bus.req_addr_o !== 32'h10) begin errors++; $display("FAIL write_addr_hold got=%h exp=00000010", bus.req_addr_o); end
  endtask

  task automatic test_read();
    logic [7:0] r [4];
    logic       low;
    int         base;
    base = req_count;
    stable_err = 0;
    cfg_stall = 3; cfg_lat = 5; cfg_rdata = 32'h1234_5678;
    load_r(32'h0000_0004);
    fork
      send_frame(5);
      begin
        get_tx_byte(r[0], 5 * 10 * BITC + 200);
        for (int i = 1; i < 4; i++) get_tx_byte(r[i], 2 * BITC);
      end
    join
    checks++; if (req_count - base != 1) begin errors++; $display("FAIL read_reqcnt got=%0d exp=1", req_count - base); end
    checks++; if (seen_addr !== 32'h4) begin errors++; $display("FAIL read_addr got=%h exp=00000004", seen_addr); end
    checks++; if (seen_wstrb !== 4'h0) begin errors++; $display("FAIL read_wstrb got=%h exp=0", seen_wstrb); end
    checks++; if (stable_err != 0) begin errors++; $display("FAIL read_stable got=%0d exp=0", stable_err); end
    checks++; if (r[0] !== 8'h78) begin errors++; $display("FAIL read_b0 got=%h exp=78", r[0]); end
    checks++; if (r[1] !== 8'h56) begin errors++; $display("FAIL read_b1 got=%h exp=56", r[1]); end
    checks++; if (r[2] !== 8'h34) begin errors++; $display("FAIL read_b2 got=%h exp=34", r[2]); end
    checks++; if (r[3] !== 8'h12) begin errors++; $display("FAIL read_b3 got=%h exp=12", r[3]); end
    wait_busy_low(low);
    checks++; if (low !== 1'b1) begin errors++; $display("FAIL read_busy_end got=%b exp=1", low); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] r;
    logic       low;
    int         base;
    base = req_count;
    frm[0] = 8'hA5;
    fork
      send_frame(1);
      get_tx_byte(r, 10 * BITC + 200);
    join
    checks++; if (r !== 8'h3F) begin errors++; $display("FAIL badop_reply got=%h exp=3f", r); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL badop_busy_stop got=%b exp=1", busy_o); end
    wait_busy_low(low);
    checks++; if (low !== 1'b1) begin errors++; $display("FAIL badop_busy_end got=%b exp=1", low); end
    checks++; if (req_count != base) begin errors++; $display("FAIL badop_noreq got=%0d exp=%0d", req_count, base); end
  endtask

  task automatic test_timeout();
    logic [7:0] r;
    logic [7:0] q [4];
    logic       low;
    cfg_stall = 0; cfg_lat = -1;
    load_r(32'h0000_0008);
    fork
      send_frame(5);
      get_tx_byte(r, 5 * 10 * BITC + TIMEOUT + 400);
    join
    checks++; if (r !== 8'h45) begin errors++; $display("FAIL tmo_reply got=%h exp=45", r); end
    checks++; if (tx_low_cyc - req_cyc != TIMEOUT + 1) begin
      errors++; $display("FAIL tmo_latency got=%0d exp=%0d", tx_low_cyc - req_cyc, TIMEOUT + 1);
    end
    wait_busy_low(low);
    checks++; if (low !== 1'b1) begin errors++; $display("FAIL tmo_busy_end got=%b exp=1", low); end
    cfg_lat = 3; cfg_rdata = 32'hCAFE_F00D;
    load_r(32'h0000_0100);
    fork
      send_frame(5);
      begin
        get_tx_byte(q[0], 5 * 10 * BITC + 200);
        for (int i = 1; i < 4; i++) get_tx_byte(q[i], 2 * BITC);
      end
    join
    checks++; if ({q[3], q[2], q[1], q[0]} !== 32'hCAFEF00D) begin
      errors++; $display("FAIL tmo_next_read got=%h exp=cafef00d", {q[3], q[2], q[1], q[0]});
    end
    checks++; if (seen_addr !== 32'h100) begin errors++; $display("FAIL tmo_next_addr got=%h exp=00000100", seen_addr); end
    wait_busy_low(low);
  endtask

  task automatic test_glitch();
    int base;
    int busy_seen;
    base = req_count;
    busy_seen = 0;
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    for (int i = 0; i < 12 * BITC; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || tx_o !== 1'b1) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL glitch_idle got=%0d exp=0", busy_seen); end
    checks++; if (req_count != base) begin errors++; $display("FAIL glitch_noreq got=%0d exp=%0d", req_count, base); end
  endtask

  task automatic test_framing();
    logic [7:0] q [4];
    logic       low;
    send_byte(8'h57, 1'b0);
    repeat (2 * BITC) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL frame_idle got=%b exp=0", busy_o); end
    cfg_stall = 0; cfg_lat = 1; cfg_rdata = 32'hA1B2_C3D4;
    load_r(32'h0000_0004);
    fork
      send_frame(5);
      begin
        get_tx_byte(q[0], 5 * 10 * BITC + 200);
        for (int i = 1; i < 4; i++) get_tx_byte(q[i], 2 * BITC);
      end
    join
    checks++; if ({q[3], q[2], q[1], q[0]} !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL frame_next_read got=%h exp=a1b2c3d4", {q[3], q[2], q[1], q[0]});
    end
    checks++; if (seen_wstrb !== 4'h0) begin errors++; $display("FAIL frame_next_wstrb got=%h exp=0", seen_wstrb); end
    wait_busy_low(low);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q [2];
    logic [7:0] r;
    int         n;
    cfg_stall = 0; cfg_lat = 1; cfg_rdata = 32'h1122_3344;
    load_r(32'h0000_000C);
    fork
      send_frame(5);
      begin
        get_tx_byte(q[0], 5 * 10 * BITC + 200);
        get_tx_byte(q[1], 2 * BITC);
      end
    join
    checks++; if ({q[1], q[0]} !== 16'h3344) begin errors++; $display("FAIL rstmid_first got=%h exp=3344", {q[1], q[0]}); end
    n = 0;
    while (tx_o !== 1'b0 && n < 2 * BITC) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * BITC) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b exp=1", tx_o); end
    checks++; if (bus.req_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", bus.req_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    checks++; if (bus.req_addr_o !== 32'h0) begin errors++; $display("FAIL rstmid_addr got=%h exp=0", bus.req_addr_o); end
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    cfg_lat = 2;
    load_w(32'h0000_0020, 32'h1234_5678);
    fork
      send_frame(9);
      get_tx_byte(r, 9 * 10 * BITC + 200);
    join
    checks++; if (r !== 8'h4B) begin errors++; $display("FAIL rstmid_wr_reply got=%h exp=4b", r); end
    checks++; if (seen_addr !== 32'h20) begin errors++; $display("FAIL rstmid_wr_addr got=%h exp=00000020", seen_addr); end
    checks++; if (seen_value !== 32'h12345678) begin errors++; $display("FAIL rstmid_wr_value got=%h exp=12345678", seen_value); end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_glitch();
    test_framing();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
